// File: rtl/imm_encoder.sv
// Immediate field encoder: maps a 32-bit constant or offset onto the instruction
// immediate field (DP rotated imm, LDR/STR offset, branch). Start/Done handshake.
module imm_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [31:0] Value,
    input  logic [1:0]  EncType,
    output logic        Busy,
    output logic        Done,
    output logic        Valid,
    output logic [23:0] ImmField,
    output logic        UBit
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned IMM_W    = 24;
    localparam int unsigned ROT_W    = 4;
    localparam int unsigned OFS_MAX  = 4095;
    localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(15);

    localparam logic [1:0] ENC_DP  = 2'b00;
    localparam logic [1:0] ENC_LS  = 2'b01;
    localparam logic [1:0] ENC_BR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SEARCH = 2'b01,
        DONE   = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [ROT_W-1:0]    rot_q, rot_d;
    logic [DATA_W-1:0]   value_q, value_d;
    logic [1:0]          enc_q, enc_d;
    logic                busy_d, done_d, valid_d, ubit_d;
    logic [IMM_W-1:0]    imm_d;

    // Candidate for the current rotation: value rotated left by 2*rot.
    logic [2*DATA_W-1:0] rot_dbl;
    logic [DATA_W-1:0]   rot_val;
    logic                dp_hit;

    assign rot_dbl = {value_q, value_q} << {rot_q, 1'b0};
    assign rot_val = rot_dbl[2*DATA_W-1:DATA_W];
    assign dp_hit  = (rot_val[DATA_W-1:8] == 24'd0);

    // Load/store offset magnitude; 0x80000000 negates to itself and fails the range test.
    logic [DATA_W-1:0]   ls_mag;
    logic                ls_ok;

    assign ls_mag = value_q[DATA_W-1] ? ((~value_q) + 32'd1) : value_q;
    assign ls_ok  = (ls_mag <= DATA_W'(OFS_MAX));

    // Branch offset must be word aligned and sign-representable in 26 bits.
    logic                br_ok;

    assign br_ok = (value_q[1:0] == 2'b00) &&
                   (value_q[31:26] == {6{value_q[25]}});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rot_q    <= '0;
            value_q  <= '0;
            enc_q    <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Valid    <= 1'b0;
            ImmField <= '0;
            UBit     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rot_q    <= rot_d;
            value_q  <= value_d;
            enc_q    <= enc_d;
            Busy     <= busy_d;
            Done     <= done_d;
            Valid    <= valid_d;
            ImmField <= imm_d;
            UBit     <= ubit_d;
        end
    end

    // Next state and result fields; results change only on the resolving edge.
    always_comb begin
        state_d = state_q;
        rot_d   = rot_q;
        value_d = value_q;
        enc_d   = enc_q;
        valid_d = Valid;
        imm_d   = ImmField;
        ubit_d  = UBit;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    value_d = Value;
                    enc_d   = EncType;
                    rot_d   = '0;
                    state_d = SEARCH;
                end
            end

            SEARCH: begin
                case (enc_q)
                    ENC_DP: begin
                        if (dp_hit) begin
                            valid_d = 1'b1;
                            imm_d   = {12'd0, rot_q, rot_val[7:0]};
                            ubit_d  = 1'b0;
                            state_d = DONE;
                        end else if (rot_q == ROT_LAST) begin
                            valid_d = 1'b0;
                            imm_d   = '0;
                            ubit_d  = 1'b0;
                            state_d = DONE;
                        end else begin
                            rot_d = rot_q + ROT_W'(1);
                        end
                    end

                    ENC_LS: begin
                        valid_d = ls_ok;
                        imm_d   = ls_ok ? {12'd0, ls_mag[11:0]} : '0;
                        ubit_d  = ls_ok ? ~value_q[DATA_W-1] : 1'b0;
                        state_d = DONE;
                    end

                    ENC_BR: begin
                        valid_d = br_ok;
                        imm_d   = br_ok ? value_q[25:2] : '0;
                        ubit_d  = 1'b0;
                        state_d = DONE;
                    end

                    default: begin
                        valid_d = 1'b0;
                        imm_d   = '0;
                        ubit_d  = 1'b0;
                        state_d = DONE;
                    end
                endcase
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

endmodule
